// File: rtl/mult_div_unit_if.sv
// Handshake and data bundle between the EX-stage controller and the multiply/divide unit.
//   start/operation/data1/data2 : launch a MULT/MULTU/DIV/DIVU
//   mthi/mtlo                   : move data1 into hi/lo while idle
//   busy/done/divByZero         : progress and result status
//   hi/lo                       : architectural HI/LO registers
interface mult_div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       operation;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, operation, data1, data2, mthi, mtlo,
        input  busy, done, divByZero, hi, lo
    );

    modport slave (
        input  start, operation, data1, data2, mthi, mtlo,
        output busy, done, divByZero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// One multiply (shift-add) or restoring-divide step per cycle, WIDTH steps,
// followed by a sign-fixup cycle that writes hi/lo, then a one-cycle done.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, aborts any running operation
//   bus   : mult_div_unit_if.slave (start/operation/data1/data2/mthi/mtlo in,
//           busy/done/divByZero/hi/lo out, all outputs registered)
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_n;
    logic             is_div_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             neg_res_q, neg_rem_q, dbz_q;
    logic [CW-1:0]    cnt_q;
    logic [AW-1:0]    acc_q;
    logic             busy_q, done_q, dbz_out_q;
    logic [WIDTH-1:0] hi_q, lo_q, hi_n, lo_n;

    // Operand capture: magnitudes and result signs
    logic             accept_c, signed_c, d1_neg_c, d2_neg_c;
    logic [WIDTH-1:0] mag1_c, mag2_c;

    assign accept_c = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
    assign signed_c = ~bus.operation[0];
    assign d1_neg_c = signed_c & bus.data1[WIDTH-1];
    assign d2_neg_c = signed_c & bus.data2[WIDTH-1];
    assign mag1_c   = d1_neg_c ? -bus.data1 : bus.data1;
    assign mag2_c   = d2_neg_c ? -bus.data2 : bus.data2;

    // Shift-add step: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]   mul_sum_c;
    logic [AW-1:0]    mul_next_c;

    assign mul_sum_c  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next_c = {mul_sum_c, acc_q[WIDTH-1:1]};

    // Restoring divide step: acc = {partial remainder, dividend/quotient bits}
    logic [WIDTH:0]   div_trial_c;
    logic [WIDTH-1:0] div_diff_c;
    logic             div_ge_c;
    logic [AW-1:0]    div_next_c;

    assign div_trial_c = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge_c    = div_trial_c >= {1'b0, b_q};
    assign div_diff_c  = div_trial_c[WIDTH-1:0] - b_q;
    assign div_next_c  = {div_ge_c ? div_diff_c : div_trial_c[WIDTH-1:0],
                          acc_q[WIDTH-2:0], div_ge_c};

    // Sign fixup of the raw magnitude results
    logic [AW-1:0]    prod_c;
    logic [WIDTH-1:0] quo_c, rem_c, dividend_c;

    assign prod_c     = neg_res_q ? -acc_q : acc_q;
    assign quo_c      = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_c      = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
    assign dividend_c = neg_rem_q ? -a_q : a_q;

    // Next state and hi/lo next values
    always_comb begin
        state_n = state_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_n = CALC;
                end else begin
                    state_n = IDLE;
                    if (bus.mthi) hi_n = bus.data1;
                    if (bus.mtlo) lo_n = bus.data1;
                end
            end
            CALC: begin
                if (cnt_q == CW'(WIDTH - 1)) state_n = FIX;
            end
            FIX: begin
                state_n = DONE;
                if (!is_div_q) begin
                    hi_n = prod_c[AW-1:WIDTH];
                    lo_n = prod_c[WIDTH-1:0];
                end else if (dbz_q) begin
                    hi_n = dividend_c;
                    lo_n = '1;
                end else begin
                    hi_n = rem_c;
                    lo_n = quo_c;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            is_div_q  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_n;
            hi_q      <= hi_n;
            lo_q      <= lo_n;
            busy_q    <= (state_n == CALC) || (state_n == FIX);
            done_q    <= (state_n == DONE);
            dbz_out_q <= (state_n == DONE) && dbz_q;
            if (accept_c) begin
                is_div_q  <= bus.operation[1];
                a_q       <= mag1_c;
                b_q       <= mag2_c;
                neg_res_q <= d1_neg_c ^ d2_neg_c;
                neg_rem_q <= d1_neg_c;
                dbz_q     <= bus.operation[1] && (bus.data2 == '0);
                cnt_q     <= '0;
                acc_q     <= bus.operation[1] ? {WIDTH'(0), mag1_c} : {WIDTH'(0), mag2_c};
            end else if (state_q == CALC) begin
                acc_q <= is_div_q ? div_next_c : mul_next_c;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.divByZero = dbz_out_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes model results, a
// negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus ();
    mult_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain integer arithmetic of the architectural operations
    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sp;
        logic [63:0] up;
        int          sa, sb;
        z = 1'b0;
        case (op)
            2'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = 64'(sp);
                h = up[63:32]; l = up[31:0];
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                h = up[63:32]; l = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    z = 1'b1; h = a; l = 32'hFFFF_FFFF;
                end else if (op == 2'd3) begin
                    l = a / b; h = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    l = 32'h8000_0000; h = 32'd0;
                end else begin
                    sa = a; sb = b;
                    l = 32'(sa / sb); h = 32'(sa % sb);
                end
            end
        endcase
    endfunction

    // Monitor: every done must match the oldest outstanding request
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", 64'(bus.done), 64'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("hi", 64'(bus.hi), 64'(e.hi));
                    chk("lo", 64'(bus.lo), 64'(e.lo));
                    chk("divByZero", 64'(bus.divByZero), 64'(e.dbz));
                    chk("latency", 64'(cyc), 64'(e.due));
                end
            end else begin
                if (bus.divByZero) chk("dbz_without_done", 64'(bus.divByZero), 64'd0);
                if (sbq.size() > 0 && cyc > sbq[0].due) begin
                    chk("done_timeout", 64'(cyc), 64'(sbq[0].due));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        bus.operation = op;
        bus.data1     = a;
        bus.data2     = b;
        bus.start     = 1'b1;
        ref_model(op, a, b, e.hi, e.lo, e.dbz);
        e.due = cyc + 34;
        sbq.push_back(e);
        step();
        bus.start     = 1'b0;
        bus.data1     = $urandom;
        bus.data2     = $urandom;
        bus.operation = 2'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && !bus.done; i++) step();
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] sp [6];
        sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 300));
        return $urandom;
    endfunction

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.operation = 2'd0; bus.data1 = '0; bus.data2 = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        repeat (3) step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dbz", 64'(bus.divByZero), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        step();

        // MULTU max*max with cycle-accurate busy/done profile
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 1; k <= 35; k++) begin
            chk($sformatf("busy_c%0d", k), 64'(bus.busy), 64'(k <= 33));
            chk($sformatf("done_c%0d", k), 64'(bus.done), 64'(k == 34));
            step();
        end

        // Signed multiply then back-to-back start in the DONE cycle
        issue(2'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done();
        issue(2'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done();
        step();

        // Signed divide and the overflow case
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        step();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        step();

        // Divide by zero then a normal DIVU
        issue(2'd3, 32'h1234_5678, 32'd0);
        wait_done();
        step();
        issue(2'd3, 32'd100, 32'd7);
        wait_done();
        step();

        // start and mthi while busy are ignored
        issue(2'd1, 32'd3, 32'd5);
        repeat (5) step();
        bus.start = 1'b1; bus.mthi = 1'b1; bus.data1 = 32'hAAAA_AAAA;
        bus.data2 = 32'd9; bus.operation = 2'd0;
        step();
        bus.start = 1'b0; bus.mthi = 1'b0;
        wait_done();
        step();

        // Moves while idle
        bus.mtlo = 1'b1; bus.data1 = 32'h5A5A_5A5A;
        step();
        bus.mtlo = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h5A5A_5A5A);
        chk("mtlo_hi", 64'(bus.hi), 64'd0);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.data1 = 32'hC3C3_3C3C;
        step();
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("mtboth_hi", 64'(bus.hi), 64'hC3C3_3C3C);
        chk("mtboth_lo", 64'(bus.lo), 64'hC3C3_3C3C);

        // start and mthi together: start wins, move dropped
        bus.mthi = 1'b1;
        issue(2'd1, 32'd2, 32'd3);
        bus.mthi = 1'b0;
        chk("start_beats_mthi", 64'(bus.hi), 64'hC3C3_3C3C);
        wait_done();
        step();

        // Reset in cycle 10 of a DIVU aborts with no result
        issue(2'd3, 32'hDEAD_BEEF, 32'd13);
        repeat (9) step();
        reset = 1'b1;
        sbq.delete();
        step();
        reset = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hi", 64'(bus.hi), 64'd0);
        chk("abort_lo", 64'(bus.lo), 64'd0);
        repeat (40) step();
        issue(2'd3, 32'hDEAD_BEEF, 32'd13);
        wait_done();
        step();

        // Randomized operations, sometimes back-to-back
        for (int n = 0; n < 30; n++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
            wait_done();
            if ($urandom_range(0, 1) == 1) step();
        end

        repeat (40) step();
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative 32-bit multiply/divide unit that sits beside the combinational ALU in the EX stage and owns the HI/LO register pair. It takes an operation code and two operands, runs a multi-cycle shift-add or restoring-divide sequence, and writes the 64-bit product or the quotient/remainder into HI/LO. A start/busy/done handshake lets the pipeline controller stall dependent MFHI/MFLO instructions until the result is ready.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE or DONE
operation  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
data1  input  WIDTH  multiplicand/dividend (rs); also the MTHI/MTLO source
data2  input  WIDTH  multiplier/divisor (rt)
mthi  input  1  write data1 into hi
mtlo  input  1  write data1 into lo
busy  output  1  operation in progress
done  output  1  one-cycle pulse; hi/lo hold the new result
divByZero  output  1  high with done when a DIV or DIVU had data2 == 0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, divByZero=0, hi=0, lo=0, iteration counter=0. Reset wins over every other input, including mid-operation: the operation is aborted and no partial result is written.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start=1: latch operation, latch magnitudes of data1/data2 (absolute values for signed ops; raw values for unsigned ops), latch result signs, counter=0, go to CALC.
- DONE + start=0: go to IDLE. DONE accepts start exactly as IDLE does, so back-to-back operations are allowed.
- CALC: one iteration per cycle for WIDTH cycles (counter 0..WIDTH-1). Multiply uses shift-add on a 2*WIDTH accumulator. Divide uses restoring division, 1 quotient bit per cycle. After the last iteration, go to FIX.
- FIX: apply signs and write hi/lo at the end of the cycle, then go to DONE.
  - MULT: 64-bit product negated if the operand signs differ.
  - DIV: quotient truncated toward zero; remainder takes the sign of the dividend.
  - Overflow case DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (DIV/DIVU with data2==0, detected at start): the sequence runs the normal length. Result is lo=0xFFFFFFFF, hi=data1 as latched. divByZero=1 during the DONE cycle.
- Results: hi=upper/remainder, lo=lower/quotient.
- busy=1 in CALC and FIX only. done=1 in DONE only. divByZero is 0 outside DONE.
- Latency: start sampled at edge 0 gives CALC in cycles 1..32, FIX in cycle 33, and DONE in cycle 34 with hi/lo already valid. The next start can be sampled at the edge ending cycle 34.
- start while busy: ignored; no effect on the running operation.
- mthi/mtlo: honoured only when busy=0 and start=0; ignored otherwise.
  - Write takes effect at the clock edge.
  - mthi and mtlo together: both hi and lo get data1.
  - start and mthi/mtlo in the same cycle: start wins and the move is dropped.
- Operands and operation may change freely after the start cycle; only the latched copies are used.
- hi/lo hold their values in all cases not listed above.

Test Plan:
- Reset, then MULTU data1=0xFFFFFFFF data2=0xFFFFFFFF. Required: busy high cycles 1..33; done=1 in cycle 34 only; hi=0xFFFFFFFE, lo=0x00000001.
- MULT data1=0xFFFFFFFD (-3) data2=7. Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Follow immediately with a back-to-back start in the DONE cycle: MULT 0x80000000*0x80000000 gives hi=0x40000000, lo=0.
- DIV data1=0xFFFFFFF9 (-7) data2=2. Required: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU data1=0x12345678 data2=0. Required: done and divByZero both high in cycle 34; lo=0xFFFFFFFF, hi=0x12345678. Then DIVU 100/7 gives lo=14, hi=2, divByZero=0.
- During a running MULTU 3*5, pulse start with new operands and assert mthi with data1=0xAAAAAAAA. Required: both ignored; result hi=0, lo=15. Then while idle assert mtlo with data1=0x5A5A5A5A: lo=0x5A5A5A5A next cycle and hi is unchanged.
- Assert reset in cycle 10 of a DIVU. Required: next cycle busy=0, done=0, hi=lo=0, state IDLE, and no done pulse follows. A fresh start afterwards completes normally in 34 cycles.
